// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants and emit-FSM state type for the SHA3-256 padder
package sha3_pkg;
    localparam int RATE_BYTES = 136;
    localparam int SLICE_W = 200;
    localparam int NSLICE = 8;
    localparam logic [7:0] PAD_DS = 8'h06;
    localparam logic [7:0] PAD_END = 8'h80;
    typedef enum logic {IDLE, EMIT} emit_state_t;
endpackage

// File: rtl/sha3_pad_emit.sv
// sha3_pad_emit: shadow register plus slice emitter for one rate block
// Ports: load/block/block_last take a completed block; ready says a load is
// accepted this cycle; pushout/doutix/dout/lastout stream 8 slices per block.
module sha3_pad_emit #(
    parameter int RB = 1088,
    parameter int SLICE_W = 200,
    parameter int NSLICE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [RB-1:0]      block,
    input  logic               block_last,
    output logic               ready,
    output logic               pushout,
    output logic [2:0]         doutix,
    output logic [SLICE_W-1:0] dout,
    output logic               lastout
);
    import sha3_pkg::*;
    localparam int FW = SLICE_W * NSLICE;
    emit_state_t state, state_nxt;
    logic [RB-1:0] shadow;
    logic [FW-1:0] blk;
    logic [2:0] ix_nxt;
    logic last_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            doutix <= '0;
            shadow <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_nxt;
            doutix <= ix_nxt;
            if (load) begin
                shadow <= block;
                last_q <= block_last;
            end
        end
    end
    always_comb begin
        state_nxt = load ? EMIT : (state == EMIT && doutix == 3'd7) ? IDLE : state;
        ix_nxt = load ? 3'd0 : (state == EMIT) ? doutix + 3'd1 : doutix;
    end
    // the last slice cycle can hand over to a pending block without a gap
    assign ready = state == IDLE || doutix == 3'd7;
    assign pushout = state == EMIT;
    // capacity bits above the rate are always zero
    assign blk = FW'(shadow);
    assign dout = pushout ? blk[32'(doutix) * SLICE_W +: SLICE_W] : '0;
    assign lastout = pushout && last_q;
endmodule

// File: rtl/sha3_pad.sv
// sha3_pad: byte accumulator with SHA3 pad10*1 (0x06 .. 0x80) feeding a slice emitter
// Ports: pushin/din/lastin byte input with stopout backpressure;
// pushout/doutix/dout/lastout carry 200-bit slices of each 1600-bit block.
module sha3_pad #(
    parameter int RATE_BYTES = sha3_pkg::RATE_BYTES,
    parameter int SLICE_W = sha3_pkg::SLICE_W,
    parameter int NSLICE = sha3_pkg::NSLICE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pushin,
    input  logic [7:0]         din,
    input  logic               lastin,
    output logic               stopout,
    output logic               pushout,
    output logic [2:0]         doutix,
    output logic [SLICE_W-1:0] dout,
    output logic               lastout
);
    import sha3_pkg::*;
    localparam int RB = RATE_BYTES * 8;
    logic [RB-1:0] acc, base, byte_bits, pad_bits;
    logic [7:0] cnt, k;
    logic full, last, pad_pend, ready, load, accept, at_end;
    assign load = full && ready;
    // a pending pad-only block replaces the accumulator on load, so no byte may enter then
    assign stopout = full && (!ready || pad_pend);
    assign accept = pushin && !stopout;
    // when a load happens the incoming byte lands in a freshly cleared accumulator
    assign base = load ? '0 : acc;
    assign k = load ? '0 : cnt;
    assign at_end = k == 8'(RATE_BYTES - 1);
    assign byte_bits = RB'(din) << {k, 3'b000};
    // 0x06 after the last byte and 0x80 in the final byte; they merge into 0x86 at k=134
    assign pad_bits = (lastin && !at_end) ?
        (((RB'(PAD_DS) << 8) << {k, 3'b000}) | (RB'(PAD_END) << (RB - 8))) : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            full <= 1'b0;
            last <= 1'b0;
            pad_pend <= 1'b0;
        end else if (accept) begin
            acc <= base | byte_bits | pad_bits;
            cnt <= (lastin || at_end) ? '0 : k + 8'd1;
            full <= lastin || at_end;
            last <= lastin && !at_end;
            pad_pend <= lastin && at_end;
        end else if (load) begin
            acc <= pad_pend ? (RB'(PAD_DS) | (RB'(PAD_END) << (RB - 8))) : '0;
            full <= pad_pend;
            last <= pad_pend;
            pad_pend <= 1'b0;
        end
    end
    sha3_pad_emit #(.RB(RB), .SLICE_W(SLICE_W), .NSLICE(NSLICE)) u_emit (
        .clk(clk),
        .reset(reset),
        .load(load),
        .block(acc),
        .block_last(last),
        .ready(ready),
        .pushout(pushout),
        .doutix(doutix),
        .dout(dout),
        .lastout(lastout)
    );
endmodule

// File: tb/tb_sha3_pad.sv
// tb_sha3_pad: randomized self-checking bench against a pad10*1 byte-queue model
module tb_sha3_pad;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {logic last; logic [2:0] ix; logic [199:0] d;} slice_t;

    logic clk = 0, reset = 1, pushin = 0, lastin = 0;
    logic [7:0] din = 0;
    logic stopout, pushout, lastout;
    logic [2:0] doutix;
    logic [199:0] dout;

    int n_tests = 0, n_fail = 0, cyc = 0, last_cyc = 0, so_cnt = 0;
    slice_t exp_q[$], obs_q[$];
    int obs_cyc[$];

    sha3_pad dut (.clk(clk), .reset(reset), .pushin(pushin), .din(din), .lastin(lastin),
                  .stopout(stopout), .pushout(pushout), .doutix(doutix), .dout(dout),
                  .lastout(lastout));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (pushout) begin
            obs_q.push_back({lastout, doutix, dout});
            obs_cyc.push_back(cyc);
            if (stopout) so_cnt++;
        end
    end

    // reference: message || 0x06 || 0* with 0x80 OR-ed into the final rate byte
    task automatic model(input bq_t m);
        bq_t p = m;
        int nb;
        p.push_back(8'h06);
        while (p.size() % 136 != 0) p.push_back(8'h00);
        p[p.size() - 1] |= 8'h80;
        nb = p.size() / 136;
        for (int b = 0; b < nb; b++) begin
            logic [1599:0] blk = '0;
            for (int i = 0; i < 136; i++) blk[8*i +: 8] = p[b*136 + i];
            for (int s = 0; s < 8; s++) exp_q.push_back({b == nb - 1, 3'(s), blk[200*s +: 200]});
        end
    endtask

    task automatic send(input bq_t m, input int gap_max, input bit with_last, output int stalls);
        stalls = 0;
        foreach (m[i]) begin
            int w = 0;
            pushin = 1;
            din = m[i];
            lastin = with_last && (i == m.size() - 1);
            @(negedge clk);
            while (stopout && w < 200) begin stalls++; w++; @(negedge clk); end
            if (stopout) begin
                n_tests++; n_fail++;
                $display("FAIL send_stall byte %0d: stopout=1 after 200 cycles, required 0", i);
            end
            if (lastin) last_cyc = cyc;
            @(posedge clk); #1;
            pushin = 0;
            lastin = 0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 3000) begin @(posedge clk); t++; end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic clr;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); so_cnt = 0;
    endtask

    task automatic do_reset;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    function automatic bq_t rnd_msg(input int n, input logic [7:0] fill, input bit use_fill);
        bq_t m;
        for (int i = 0; i < n; i++) m.push_back(use_fill ? fill : 8'($urandom_range(0, 255)));
        return m;
    endfunction

    task automatic test_reset;
        do_reset();
        n_tests++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL reset_pushout got %b required 0", pushout); end
        n_tests++; if (doutix !== 3'd0) begin n_fail++; $display("FAIL reset_doutix got %0d required 0", doutix); end
        n_tests++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h required 0", dout); end
        n_tests++; if (stopout !== 1'b0) begin n_fail++; $display("FAIL reset_stopout got %b required 0", stopout); end
        n_tests++; if (lastout !== 1'b0) begin n_fail++; $display("FAIL reset_lastout got %b required 0", lastout); end
    endtask

    task automatic test_abc;
        bq_t m = '{8'h61, 8'h62, 8'h63};
        logic [199:0] e5 = 200'h80 << 80;
        int st;
        clr(); model(m);
        send(m, 0, 1, st);
        drain(8);
        n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL abc_count got %0d required 8", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abc_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 8) begin
            n_tests++; if (obs_q[0].d !== 200'h06636261) begin n_fail++; $display("FAIL abc_s0 got %h required 06636261", obs_q[0].d); end
            n_tests++; if (obs_q[5].d !== e5) begin n_fail++; $display("FAIL abc_s5 got %h required %h", obs_q[5].d, e5); end
            n_tests++; if (obs_cyc[0] != last_cyc + 2) begin n_fail++; $display("FAIL abc_latency got %0d required %0d", obs_cyc[0] - last_cyc, 2); end
            n_tests++; if (obs_cyc[7] != last_cyc + 9) begin n_fail++; $display("FAIL abc_span got %0d required %0d", obs_cyc[7] - last_cyc, 9); end
        end
    endtask

    task automatic test_135;
        bq_t m = rnd_msg(135, 8'hAA, 1);
        int st;
        clr(); model(m);
        send(m, 1, 1, st);
        drain(8);
        n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL b135_count got %0d required 8", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b135_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 8) begin
            n_tests++; if (obs_q[5].d[87:80] !== 8'h86) begin n_fail++; $display("FAIL b135_byte135 got %h required 86", obs_q[5].d[87:80]); end
        end
    endtask

    task automatic test_136;
        bq_t m = rnd_msg(136, 8'h00, 0);
        int st;
        clr(); model(m);
        send(m, 0, 1, st);
        drain(16);
        n_tests++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL b136_count got %0d required 16", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b136_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        n_tests++; if (so_cnt == 0) begin n_fail++; $display("FAIL b136_stopout got %0d stalled emit cycles, required >0", so_cnt); end
        if (obs_q.size() == 16) begin
            n_tests++; if (obs_cyc[15] - obs_cyc[0] != 15) begin n_fail++; $display("FAIL b136_gapless got span %0d required 15", obs_cyc[15] - obs_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid;
        bq_t junk = rnd_msg(50, 8'h00, 0);
        bq_t m = '{8'h61, 8'h62, 8'h63};
        int st;
        send(junk, 0, 0, st);
        do_reset();
        clr(); model(m);
        send(m, 0, 1, st);
        drain(8);
        n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL rmid_count got %0d required 8", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bq_t m1 = rnd_msg(300, 8'h00, 0);
        bq_t m2 = '{8'h61, 8'h62, 8'h63};
        int st1, st2;
        clr(); model(m1); model(m2);
        send(m1, 0, 1, st1);
        send(m2, 0, 1, st2);
        drain(32);
        n_tests++; if (st1 != 0) begin n_fail++; $display("FAIL b2b_stall got %0d stalls required 0", st1); end
        n_tests++; if (obs_q.size() != 32) begin n_fail++; $display("FAIL b2b_count got %0d required 32", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random;
        int st;
        clr();
        for (int r = 0; r < 6; r++) begin
            bq_t m = rnd_msg($urandom_range(1, 300), 8'h00, 0);
            model(m);
            send(m, 2, 1, st);
        end
        drain(exp_q.size());
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count got %0d required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_slice%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_emit;
        bq_t m = '{8'h61, 8'h62, 8'h63};
        int st, t = 0, n0;
        clr();
        send(m, 0, 1, st);
        @(negedge clk);
        while (!(pushout && doutix == 3'd3) && t < 50) begin t++; @(negedge clk); end
        n_tests++; if (t >= 50) begin n_fail++; $display("FAIL remit_reach got no doutix=3 within 50 cycles, required one"); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        n_tests++; if (pushout !== 1'b0) begin n_fail++; $display("FAIL remit_pushout got %b required 0", pushout); end
        n_tests++; if ({doutix, dout, stopout, lastout} !== '0) begin n_fail++; $display("FAIL remit_outputs got ix=%0d dout=%h so=%b lo=%b required all 0", doutix, dout, stopout, lastout); end
        n0 = obs_q.size();
        repeat (12) @(posedge clk);
        n_tests++; if (obs_q.size() != n0) begin n_fail++; $display("FAIL remit_truncate got %0d extra slices required 0", obs_q.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_135();
        test_136();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_reset_emit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
